pipe_id_interlock: RTL and testbench
====================================

Name: pipe_id_interlock

Overview:
- Parametrised decode-stage hazard and forwarding unit for the 5-stage pipeline.
- Successor to the fixed 32x32 ID-stage forwarding logic. Adds three things that logic lacks:
  - branch-compare interlocks, for branches resolved in ID;
  - a multi-cycle MDU (mult/div) busy scoreboard with HI/LO hazard stalls;
  - a saturating stall performance counter.
- Sits between the register file read ports and the ID/EX pipeline register. It drives the PC/IR write enable and the bubble insert.

Parameters:
- XLEN, 32: datapath width.
- NREG, 32: architectural register count. AW = $clog2(NREG). Register 0 is hard-wired zero.
- MUL_LAT, 4: cycles from accepted mult until HI/LO valid, >=1.
- DIV_LAT, 32: cycles from accepted div until HI/LO valid, >=1.
- CW, 32: stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- rs, rt  in  AW  source register numbers.
- use_rs, use_rt  in  1  instruction reads rs / rt.
- id_branch  in  1  instruction compares operands in ID (beq/bne/jr).
- id_mdu_op  in  1  instruction is mult or div.
- id_mdu_div  in  1  1 = div, 0 = mult; valid when id_mdu_op=1.
- id_hilo_rd  in  1  instruction is mfhi or mflo.
- ern, mrn  in  AW  destination register in EX / MEM.
- ewreg, em2reg, mwreg, mm2reg  in  1  write-enable and load flags for EX / MEM.
- qa, qb  in  XLEN  register file read data.
- ealu, malu, mmo  in  XLEN  EX ALU result, MEM ALU result, MEM load data.
- da, db  out  XLEN  forwarded operands.
- fwda, fwdb  out  2  mux selects: 00 qa/qb, 01 ealu, 10 malu, 11 mmo.
- wpcir  out  1  PC/IR write enable, active low on stall.
- bubble  out  1  zero the ID/EX control signals this cycle.
- mdu_start  out  1  one-cycle pulse launching the MDU.
- mdu_busy  out  1  MDU result pending.
- stall_cnt  out  CW  count of stalled cycles.

Behaviour:
- Forwarding (combinational), per operand X in {rs, rt}:
  - If ewreg & ~em2reg & ern==X & X!=0, select 01.
  - Else if mwreg & mrn==X & X!=0, select 11 when mm2reg, else 10.
  - Else select 00.
  - EX has priority over MEM. Register 0 is never forwarded.
  - da/db = mux(fwd). These values are used for branch compare and for ID/EX.
- Stall sources, all gated by id_valid:
  - lu: ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
  - br_e: id_branch & ewreg & ern!=0 & match as above (EX result not ready for ID compare).
  - br_m: id_branch & mwreg & mm2reg & mrn!=0 & match.
  - md: mdu_busy & (id_hilo_rd | id_mdu_op).
- stall = lu | br_e | br_m | md. Then wpcir = ~stall, bubble = stall.
- MDU counter cnt: a register wide enough for max(MUL_LAT, DIV_LAT). Reset value 0.
  - mdu_busy = (cnt != 0).
  - mdu_start = id_valid & id_mdu_op & ~stall.
  - On mdu_start: cnt <= id_mdu_div ? DIV_LAT : MUL_LAT.
  - Else if cnt != 0: cnt <= cnt - 1.
  - While cnt==1, busy is still 1 and dependent instructions still stall. They are accepted in the cycle cnt==0.
  - A new mdu_start cannot coincide with busy=1; the md stall blocks it.
- stall_cnt: increments by 1 on each cycle with stall=1. Saturates at all-ones with no wrap. Reset value 0.
- Reset values: cnt=0, stall_cnt=0. With id_valid=0: mdu_busy=0, mdu_start=0, wpcir=1, bubble=0.
- Reset asserted mid-division: cnt=0 on the next edge; mdu_busy drops the cycle after.
- id_valid=0: no stall, no mdu_start. The counter still decrements.
- Simultaneous sources: stall is the OR of all sources. stall_cnt counts a stalled cycle once, not once per source.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_REG=2'b00, FWD_EALU=2'b01, FWD_MALU=2'b10, FWD_MMO=2'b11;
  - default latency constants MUL_LAT_DEF, DIV_LAT_DEF.
- One sub-module, pipe_mdu_sb: the MDU countdown scoreboard. It has inputs clk, reset, start, is_div and output busy.
- Forwarding and stall logic stay inline.

Test Plan:
- EX=add r5 (ewreg=1, em2reg=0, ern=5), ID uses rs=5, ealu=0x11 -> fwda=01, da=0x11, wpcir=1.
- EX=lw r3 (em2reg=1, ern=3), ID use_rt, rt=3 -> wpcir=0, bubble=1 for one cycle. Next cycle lw is in MEM with mmo=0xABCD -> fwdb=11, db=0xABCD, stall_cnt=1.
- ID beq on r7 with EX writing r7 (ALU op) -> 1-cycle stall. Next cycle fwd=10 and compare uses malu.
- div accepted (DIV_LAT=32), then mflo in ID -> mdu_start pulses once, mflo stalls exactly 32 cycles, then is accepted with mdu_busy=0 and stall_cnt=32.
- reset asserted after 10 cycles of an active div -> cnt=0 next cycle, mdu_busy=0, stall_cnt=0, wpcir=1.
- Register 0: EX writes r0 with ewreg=1 while ID uses rs=0 -> fwda=00, no stall, even when em2reg=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the decode-stage hazard unit and its MDU scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMO  = 2'b11;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/pipe_mdu_sb.sv
// MDU countdown scoreboard: tracks cycles until HI/LO become valid.
// Latency: busy rises the cycle after start and stays high for MUL_LAT/DIV_LAT cycles.
// Backpressure: none; the caller must not start while busy.
module pipe_mdu_sb
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNTW    = $clog2(MAX_LAT + 1);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNTW'(DIV_LAT) : CNTW'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
        end
    end

    // Still busy while cnt==1; dependents are released only once it reaches 0.
    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_id_interlock.sv
// ID-stage operand forwarding, load/branch/MDU interlocks and stall counting.
// Latency: forwarding and stall are combinational; stall_cnt updates on the next edge.
// Backpressure: stall drops wpcir and inserts a bubble; the ID instruction is held.
module pipe_id_interlock
    import pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CW      = 32,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            id_branch,
    input  logic            id_mdu_op,
    input  logic            id_mdu_div,
    input  logic            id_hilo_rd,
    input  logic [AW-1:0]   ern,
    input  logic [AW-1:0]   mrn,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [XLEN-1:0] qa,
    input  logic [XLEN-1:0] qb,
    input  logic [XLEN-1:0] ealu,
    input  logic [XLEN-1:0] malu,
    input  logic [XLEN-1:0] mmo,
    output logic [XLEN-1:0] da,
    output logic [XLEN-1:0] db,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            wpcir,
    output logic            bubble,
    output logic            mdu_start,
    output logic            mdu_busy,
    output logic [CW-1:0]   stall_cnt
);

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] r,
        input logic [AW-1:0] e_rn,
        input logic          e_wr,
        input logic          e_ld,
        input logic [AW-1:0] m_rn,
        input logic          m_wr,
        input logic          m_ld
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (r != '0) begin
            if (e_wr && !e_ld && e_rn == r) begin
                sel = FWD_EALU;
            end else if (m_wr && m_rn == r) begin
                sel = m_ld ? FWD_MMO : FWD_MALU;
            end
        end
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] e,
        input logic [XLEN-1:0] m,
        input logic [XLEN-1:0] l
    );
        logic [XLEN-1:0] v;
        unique case (sel)
            FWD_EALU: v = e;
            FWD_MALU: v = m;
            FWD_MMO:  v = l;
            default:  v = q;
        endcase
        return v;
    endfunction

    always_comb begin
        fwda = fwd_sel(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        fwdb = fwd_sel(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        da   = fwd_mux(fwda, qa, ealu, malu, mmo);
        db   = fwd_mux(fwdb, qb, ealu, malu, mmo);
    end

    logic e_match;
    logic m_match;
    logic stall_lu;
    logic stall_br_e;
    logic stall_br_m;
    logic stall_md;
    logic stall;

    always_comb begin
        e_match    = (ern != '0) && ((use_rs && ern == rs) || (use_rt && ern == rt));
        m_match    = (mrn != '0) && ((use_rs && mrn == rs) || (use_rt && mrn == rt));
        stall_lu   = ewreg && em2reg && e_match;
        // Operands for an ID compare must exist by ID; an EX result never does.
        stall_br_e = id_branch && ewreg && e_match;
        stall_br_m = id_branch && mwreg && mm2reg && m_match;
        stall_md   = mdu_busy && (id_hilo_rd || id_mdu_op);
        stall      = id_valid && (stall_lu || stall_br_e || stall_br_m || stall_md);
        wpcir      = !stall;
        bubble     = stall;
        mdu_start  = id_valid && id_mdu_op && !stall;
    end

    pipe_mdu_sb #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_sb (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start),
        .is_div (id_mdu_div),
        .busy   (mdu_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_id_interlock.sv
// Self-checking bench for pipe_id_interlock: constant vector table, directed
// multi-cycle sequences and randomized traffic against a timestamp-based model.
module tb_pipe_id_interlock;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int MULL   = 4;
    localparam int DIVL   = 32;
    localparam int CW     = 6;
    localparam int SATMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, use_rs, use_rt, id_branch, id_mdu_op, id_mdu_div, id_hilo_rd;
    logic [AW-1:0]   rs, rt, ern, mrn;
    logic            ewreg, em2reg, mwreg, mm2reg;
    logic [XLEN-1:0] qa, qb, ealu, malu, mmo;
    logic [XLEN-1:0] da, db;
    logic [1:0]      fwda, fwdb;
    logic            wpcir, bubble, mdu_start, mdu_busy;
    logic [CW-1:0]   stall_cnt;

    pipe_id_interlock #(
        .XLEN(XLEN), .NREG(NREG), .MUL_LAT(MULL), .DIV_LAT(DIVL), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .id_branch(id_branch),
        .id_mdu_op(id_mdu_op), .id_mdu_div(id_mdu_div), .id_hilo_rd(id_hilo_rd),
        .ern(ern), .mrn(mrn), .ewreg(ewreg), .em2reg(em2reg), .mwreg(mwreg),
        .mm2reg(mm2reg), .qa(qa), .qb(qb), .ealu(ealu), .malu(malu), .mmo(mmo),
        .da(da), .db(db), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: cycle index, cycle at which HI/LO become valid, stalled-cycle count.
    int cyc = 0;
    int ready_at = 0;
    int scnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] r);
        if (r == 0) return 2'b00;
        if (ewreg && !em2reg && ern == r) return 2'b01;
        if (mwreg && mrn == r) return mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] m_val(input logic [1:0] f, input logic [XLEN-1:0] q);
        case (f)
            2'b01:   return ealu;
            2'b10:   return malu;
            2'b11:   return mmo;
            default: return q;
        endcase
    endfunction

    function automatic bit reads(input logic [AW-1:0] r);
        return r != 0 && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

    task automatic idle_inputs();
        id_valid = 0; use_rs = 0; use_rt = 0; id_branch = 0; id_mdu_op = 0;
        id_mdu_div = 0; id_hilo_rd = 0; rs = 0; rt = 0; ern = 0; mrn = 0;
        ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        qa = 32'hA0; qb = 32'hB0; ealu = 32'h11; malu = 32'h22; mmo = 32'h33;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check every output against the model, then advance across one rising edge.
    task automatic tick(input bit do_chk = 1);
        bit busy, stall, start;
        logic [1:0] fa, fb;
        busy  = cyc < ready_at;
        fa    = m_fwd(rs);
        fb    = m_fwd(rt);
        stall = id_valid && ((ewreg && em2reg && reads(ern)) ||
                             (id_branch && ewreg && reads(ern)) ||
                             (id_branch && mwreg && mm2reg && reads(mrn)) ||
                             (busy && (id_hilo_rd || id_mdu_op)));
        start = id_valid && id_mdu_op && !stall;
        if (do_chk) begin
            chk("fwda", fwda, fa);
            chk("fwdb", fwdb, fb);
            chk("da", da, m_val(fa, qa));
            chk("db", db, m_val(fb, qb));
            chk("wpcir", wpcir, !stall);
            chk("bubble", bubble, stall);
            chk("mdu_start", mdu_start, start);
            chk("mdu_busy", mdu_busy, busy);
            chk("stall_cnt", stall_cnt, scnt);
        end
        if (reset) begin
            ready_at = 0;
            scnt = 0;
        end else begin
            if (start) ready_at = cyc + 1 + (id_mdu_div ? DIVL : MULL);
            if (stall && scnt < SATMAX) scnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        settle();
        tick(0);
        reset = 0;
    endtask

    typedef struct {
        logic v, br, urs, urt, ew, em, mw, mm;
        logic [AW-1:0] rs, rt, ern, mrn;
        logic [1:0] efa, efb;
        logic est;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int starts;
        //             v  br urs urt ew em mw mm  rs rt ern mrn efa    efb    stall
        tbl[0]  = '{1, 0, 1, 0, 1, 0, 0, 0, 5, 6, 5, 0, 2'b01, 2'b00, 0};
        tbl[1]  = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 3, 3, 0, 2'b00, 2'b00, 1};
        tbl[2]  = '{1, 0, 0, 1, 0, 0, 1, 1, 1, 3, 0, 3, 2'b00, 2'b11, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 0, 1, 0, 4, 2, 0, 4, 2'b10, 2'b00, 0};
        tbl[4]  = '{1, 0, 1, 1, 1, 0, 1, 1, 9, 9, 9, 9, 2'b01, 2'b01, 0};
        tbl[5]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b00, 2'b00, 0};
        tbl[6]  = '{1, 1, 1, 0, 1, 0, 0, 0, 7, 1, 7, 0, 2'b01, 2'b00, 1};
        tbl[7]  = '{1, 1, 1, 0, 0, 0, 1, 1, 7, 1, 0, 7, 2'b11, 2'b00, 1};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 1, 0, 7, 1, 0, 7, 2'b10, 2'b00, 0};
        tbl[9]  = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 8, 8, 0, 2'b00, 2'b00, 0};
        tbl[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 3, 3, 0, 2'b00, 2'b00, 0};
        tbl[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0};

        idle_inputs();
        reset = 1;
        @(negedge clk);
        settle(); tick(0);
        settle(); tick(0);
        reset = 0;

        // Post-reset state.
        settle();
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mdu_busy", mdu_busy, 0);
        chk("rst_mdu_start", mdu_start, 0);
        chk("rst_wpcir", wpcir, 1);
        chk("rst_bubble", bubble, 0);
        tick();

        foreach (tbl[i]) begin
            idle_inputs();
            id_valid = tbl[i].v; id_branch = tbl[i].br; use_rs = tbl[i].urs; use_rt = tbl[i].urt;
            ewreg = tbl[i].ew; em2reg = tbl[i].em; mwreg = tbl[i].mw; mm2reg = tbl[i].mm;
            rs = tbl[i].rs; rt = tbl[i].rt; ern = tbl[i].ern; mrn = tbl[i].mrn;
            settle();
            chk($sformatf("tbl%0d_fwda", i), fwda, tbl[i].efa);
            chk($sformatf("tbl%0d_fwdb", i), fwdb, tbl[i].efb);
            chk($sformatf("tbl%0d_stall", i), bubble, tbl[i].est);
            tick();
        end

        // Load-use: one-cycle stall, then MEM load data forwarded.
        idle_inputs(); do_reset();
        id_valid = 1; use_rt = 1; rt = 3; ewreg = 1; em2reg = 1; ern = 3;
        settle();
        chk("lu_wpcir", wpcir, 0);
        chk("lu_bubble", bubble, 1);
        tick();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 3; mmo = 32'hABCD;
        settle();
        chk("lu_fwdb", fwdb, 2'b11);
        chk("lu_db", db, 32'hABCD);
        chk("lu_wpcir2", wpcir, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();

        // Branch on an ALU result still in EX: stall, then compare uses malu.
        idle_inputs();
        id_valid = 1; id_branch = 1; use_rs = 1; use_rt = 1; rs = 7; rt = 2;
        ewreg = 1; ern = 7; ealu = 32'h77;
        settle();
        chk("br_stall", wpcir, 0);
        tick();
        ewreg = 0; ern = 0; mwreg = 1; mrn = 7; malu = 32'h77;
        settle();
        chk("br_fwda", fwda, 2'b10);
        chk("br_da", da, 32'h77);
        chk("br_wpcir", wpcir, 1);
        tick();

        // div then mflo: exactly DIV_LAT stalled cycles.
        idle_inputs(); do_reset();
        id_valid = 1; id_mdu_op = 1; id_mdu_div = 1;
        settle();
        chk("div_start", mdu_start, 1);
        tick();
        id_mdu_op = 0; id_mdu_div = 0; id_hilo_rd = 1;
        n = 0; starts = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (wpcir) break;
            n++;
            starts += mdu_start;
            tick();
        end
        chk("div_stall_len", n, DIVL);
        chk("div_extra_start", starts, 0);
        chk("div_busy_end", mdu_busy, 0);
        chk("div_stall_cnt", stall_cnt, DIVL);
        tick();

        // Reset in the middle of a division.
        idle_inputs();
        id_valid = 1; id_mdu_op = 1; id_mdu_div = 1;
        settle(); tick();
        idle_inputs();
        for (int k = 0; k < 10; k++) begin settle(); tick(); end
        settle();
        chk("mid_busy_pre", mdu_busy, 1);
        reset = 1;
        tick();
        reset = 0;
        id_valid = 1; id_hilo_rd = 1;
        settle();
        chk("mid_busy", mdu_busy, 0);
        chk("mid_stall_cnt", stall_cnt, 0);
        chk("mid_wpcir", wpcir, 1);
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 59) == 0);
            id_valid   = ($urandom_range(0, 7) != 0);
            rs         = AW'($urandom_range(0, 3));
            rt         = AW'($urandom_range(0, 3));
            use_rs     = $urandom_range(0, 1);
            use_rt     = $urandom_range(0, 1);
            id_branch  = ($urandom_range(0, 3) == 0);
            id_mdu_op  = ($urandom_range(0, 9) == 0);
            id_mdu_div = $urandom_range(0, 1);
            id_hilo_rd = ($urandom_range(0, 5) == 0);
            ern        = AW'($urandom_range(0, 3));
            mrn        = AW'($urandom_range(0, 3));
            ewreg      = $urandom_range(0, 1);
            em2reg     = $urandom_range(0, 1);
            mwreg      = $urandom_range(0, 1);
            mm2reg     = $urandom_range(0, 1);
            qa = $urandom; qb = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
            settle();
            tick();
        end
        reset = 0;

        // Saturation: a held load-use hazard drives the counter to all-ones and keeps it there.
        idle_inputs(); do_reset();
        id_valid = 1; use_rs = 1; rs = 4; ewreg = 1; em2reg = 1; ern = 4;
        for (int k = 0; k < SATMAX + 5; k++) begin settle(); tick(); end
        settle();
        chk("sat_cnt", stall_cnt, SATMAX);
        tick();
        settle();
        chk("sat_hold", stall_cnt, SATMAX);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
